// File: rtl/xillybus_rd_packetizer_pkg.sv
// Shared types and default widths for the Xillybus read packetizer.
// Optional statistics counters are enabled with XRP_STATS_EN.
package xrp_pkg;

  localparam int DEF_DW = 32;
  localparam int DEF_AW = 4;
  localparam int DEF_LW = 16;

  typedef enum logic {
    STREAM = 1'b0,
    DONE   = 1'b1
  } state_t;

endpackage

// File: rtl/xillybus_rd_packetizer_if.sv
// Producer and Xillybus read-stream signals of the packetizer.
// master = HLS core / host side, slave = packetizer.
interface xrp_if
  import xrp_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int LW = DEF_LW
);

  logic [DW-1:0] in_din;
  logic          in_write;
  logic          in_full_n;
  logic [LW-1:0] pkt_len;
  logic          user_r_rden;
  logic          user_r_empty;
  logic [DW-1:0] user_r_data;
  logic          user_r_eof;
  logic          user_r_open;
  logic          overflow;

  modport master (
    output in_din,
    output in_write,
    output pkt_len,
    output user_r_rden,
    output user_r_open,
    input  in_full_n,
    input  user_r_empty,
    input  user_r_data,
    input  user_r_eof,
    input  overflow
  );

  modport slave (
    input  in_din,
    input  in_write,
    input  pkt_len,
    input  user_r_rden,
    input  user_r_open,
    output in_full_n,
    output user_r_empty,
    output user_r_data,
    output user_r_eof,
    output overflow
  );

endinterface

// File: rtl/xillybus_rd_packetizer_fifo.sv
// Synchronous FIFO, AW+1 bit pointers, registered dout, sync clear.
// A write at full is taken only when a read frees a slot that cycle.
module xrp_sync_fifo
  import xrp_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2**AW];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          rd_ok;
  logic          wr_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok && !clr)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/xillybus_rd_packetizer.sv
// HLS ap_fifo to Xillybus read-stream bridge with per-session EOF.
// Define XRP_STATS_EN to add word_count / pkt_count outputs.
module xillybus_rd_packetizer
  import xrp_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int LW = DEF_LW
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  xrp_if.slave        bus
`ifdef XRP_STATS_EN
  ,
  output logic [31:0] word_count,
  output logic [31:0] pkt_count
`endif
);

  state_t        state;
  logic [LW-1:0] cnt;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_eff;
  logic          last;
  logic          rd_acc;
  logic          wr_req;
  logic          ovf_ev;
  logic          ovf_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;

  assign rd_acc = bus.user_r_open && (state == STREAM) &&
                  bus.user_r_rden && !fifo_empty;
  assign wr_req = bus.user_r_open && bus.in_write;
  assign ovf_ev = wr_req && fifo_full && !rd_acc;

  // Length is taken live on the first read of a session, latched after.
  assign len_eff = (cnt == '0) ? bus.pkt_len : len_q;
  assign last    = (len_eff != '0) && (cnt == len_eff - LW'(1));

  xrp_sync_fifo #(
    .DW (DW),
    .AW (AW)
  ) u_fifo (
    .clk   (bus_clk),
    .rst_n (bus_rst_n),
    .clr   (!bus.user_r_open),
    .wr_en (wr_req),
    .din   (bus.in_din),
    .rd_en (rd_acc),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state <= STREAM;
      cnt   <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
    end else if (!bus.user_r_open) begin
      state <= STREAM;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (ovf_ev)
        ovf_q <= 1'b1;
      if (rd_acc) begin
        cnt <= cnt + LW'(1);
        if (cnt == '0)
          len_q <= bus.pkt_len;
        if (last)
          state <= DONE;
      end
    end
  end

  // Closed channel never back-pressures the HLS core.
  assign bus.in_full_n    = !bus.user_r_open || !fifo_full;
  assign bus.user_r_empty = (state == DONE) || fifo_empty;
  assign bus.user_r_eof   = (state == DONE);
  assign bus.user_r_data  = fifo_dout;
  assign bus.overflow     = ovf_q;

`ifdef XRP_STATS_EN
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      word_count <= '0;
      pkt_count  <= '0;
    end else begin
      if (rd_acc)
        word_count <= word_count + 32'd1;
      if (rd_acc && last)
        pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xillybus_rd_packetizer.sv
// Directed bench for xillybus_rd_packetizer.
// Stats outputs are checked when XRP_STATS_EN is defined.
module tb_xillybus_rd_packetizer;

  bit clk;
  logic rst_n;
  int total;
  int passed;
  int fails;

  always #5 clk = ~clk;

  xrp_if #(.DW(32), .LW(16)) bus ();

`ifdef XRP_STATS_EN
  logic [31:0] word_count;
  logic [31:0] pkt_count;
`endif

  xillybus_rd_packetizer #(
    .DW (32),
    .AW (4),
    .LW (16)
  ) dut (
    .bus_clk   (clk),
    .bus_rst_n (rst_n),
    .bus       (bus)
`ifdef XRP_STATS_EN
    ,
    .word_count (word_count),
    .pkt_count  (pkt_count)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d);
    bus.in_write = 1'b1;
    bus.in_din   = d;
    tick();
    bus.in_write = 1'b0;
  endtask

  task automatic rd();
    bus.user_r_rden = 1'b1;
    tick();
    bus.user_r_rden = 1'b0;
  endtask

  task automatic reopen();
    bus.user_r_open = 1'b0;
    tick();
    bus.user_r_open = 1'b1;
  endtask

  initial begin
    int occ;
    int wn;
    int rn;
    logic w;
    logic r;
    logic racc;

    total  = 0;
    passed = 0;
    fails  = 0;
    rst_n  = 1'b0;
    bus.in_din      = '0;
    bus.in_write    = 1'b0;
    bus.pkt_len     = '0;
    bus.user_r_rden = 1'b0;
    bus.user_r_open = 1'b0;
    tick();
    tick();
    chk("rst_full_n", bus.in_full_n, 1);
    chk("rst_empty", bus.user_r_empty, 1);
    chk("rst_data", bus.user_r_data, 0);
    chk("rst_eof", bus.user_r_eof, 0);
    chk("rst_ovf", bus.overflow, 0);
    rst_n = 1'b1;
    bus.user_r_open = 1'b1;
    bus.pkt_len = 16'd4;
    tick();

    // pkt_len=4, six words written, four presented
    for (int i = 0; i < 6; i++)
      wr(32'hA0 + i);
    chk("p4_empty0", bus.user_r_empty, 0);
    for (int i = 0; i < 4; i++) begin
      rd();
      chk("p4_data", bus.user_r_data, 32'hA0 + i);
      chk("p4_eof", bus.user_r_eof, (i == 3));
      if (i == 0)
        bus.pkt_len = 16'd100;
    end
    chk("p4_empty1", bus.user_r_empty, 1);
    for (int i = 0; i < 5; i++) begin
      rd();
      chk("done_data", bus.user_r_data, 32'hA3);
      chk("done_eof", bus.user_r_eof, 1);
      chk("done_empty", bus.user_r_empty, 1);
    end
    wr(32'hB0);
    chk("done_eof_w", bus.user_r_eof, 1);
`ifdef XRP_STATS_EN
    chk("st_words", word_count, 4);
    chk("st_pkts", pkt_count, 1);
`endif
    bus.user_r_open = 1'b0;
    wr(32'hC0);
    chk("cl_eof", bus.user_r_eof, 0);
    chk("cl_empty", bus.user_r_empty, 1);
    chk("cl_data", bus.user_r_data, 32'hA3);
    chk("cl_full_n", bus.in_full_n, 1);
    bus.user_r_open = 1'b1;
    tick();
    chk("ro_empty", bus.user_r_empty, 1);

    // pkt_len=0, 40 words with random gaps on both sides
    bus.pkt_len = 16'd0;
    occ = 0;
    wn  = 0;
    rn  = 0;
    for (int c = 0; c < 600 && rn < 40; c++) begin
      w = (wn < 40) && (occ < 16) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      racc = r && (occ > 0);
      bus.in_write    = w;
      bus.in_din      = 32'h100 + wn;
      bus.user_r_rden = r;
      tick();
      if (w) begin
        wn++;
        occ++;
      end
      if (racc) begin
        chk("s_data", bus.user_r_data, 32'h100 + rn);
        rn++;
        occ--;
      end
      chk("s_empty", bus.user_r_empty, (occ == 0));
      chk("s_eof", bus.user_r_eof, 0);
    end
    bus.in_write    = 1'b0;
    bus.user_r_rden = 1'b0;
    chk("s_count", rn, 40);

    // fill to full, overflow, simultaneous read+write at full
    for (int i = 0; i < 16; i++)
      wr(32'h10 + i);
    chk("f_full_n", bus.in_full_n, 0);
    chk("f_ovf0", bus.overflow, 0);
    wr(32'hEE);
    chk("f_ovf1", bus.overflow, 1);
    bus.in_write    = 1'b1;
    bus.in_din      = 32'h55;
    bus.user_r_rden = 1'b1;
    tick();
    bus.in_write    = 1'b0;
    bus.user_r_rden = 1'b0;
    chk("f_rw_data", bus.user_r_data, 32'h10);
    chk("f_rw_full", bus.in_full_n, 0);
    for (int i = 1; i < 16; i++) begin
      rd();
      chk("f_drain", bus.user_r_data, 32'h10 + i);
    end
    rd();
    chk("f_last", bus.user_r_data, 32'h55);
    chk("f_empty", bus.user_r_empty, 1);

    // pkt_len=3 with a close mid-packet
    reopen();
    chk("c_ovf_clr", bus.overflow, 0);
    bus.pkt_len = 16'd3;
    for (int i = 0; i < 5; i++)
      wr(32'h30 + i);
    rd();
    chk("c_d0", bus.user_r_data, 32'h30);
    rd();
    chk("c_d1", bus.user_r_data, 32'h31);
    reopen();
    tick();
    chk("c_empty", bus.user_r_empty, 1);
    chk("c_ovf", bus.overflow, 0);
    for (int i = 0; i < 4; i++)
      wr(32'h40 + i);
    for (int i = 0; i < 3; i++) begin
      rd();
      chk("c_data", bus.user_r_data, 32'h40 + i);
      chk("c_eof", bus.user_r_eof, (i == 2));
    end

    // async reset mid-packet
    reopen();
    bus.pkt_len = 16'd4;
    for (int i = 0; i < 17; i++)
      wr(32'h60 + i);
    rd();
    chk("a_pre_ovf", bus.overflow, 1);
    chk("a_pre_data", bus.user_r_data, 32'h60);
    rst_n = 1'b0;
    #2;
    chk("a_full_n", bus.in_full_n, 1);
    chk("a_empty", bus.user_r_empty, 1);
    chk("a_data", bus.user_r_data, 0);
    chk("a_eof", bus.user_r_eof, 0);
    chk("a_ovf", bus.overflow, 0);
`ifdef XRP_STATS_EN
    chk("a_words", word_count, 0);
    chk("a_pkts", pkt_count, 0);
`endif
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
